bounce_box_gen: RTL and testbench

Animated pixel source that sits directly downstream of VGA_sync, in parallel with pixel_gen. It consumes the pixel coordinates and video_on from VGA_sync and draws a white one-pixel screen border plus a solid square that moves one step per frame. The square bounces off the active-area edges and changes colour on every bounce. Its registered RGB drives the colour outputs of the top level.

---
 rtl/vga_pkg.sv | 14 +
 rtl/bounce_box_gen_if.sv | 9 +
 rtl/bounce_box_gen_axis.sv | 36 +++
 rtl/bounce_box_gen.sv | 65 ++++++
 tb/tb_bounce_box_gen.sv | 123 ++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, bounce palette and FSM state type
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int HF = 16;
  localparam int HR = 96;
  localparam int VF = 10;
  localparam int VR = 2;
  localparam logic [7:0][11:0] PALETTE = {12'h888, 12'hF80, 12'hF0F, 12'h0FF,
                                          12'hFF0, 12'h00F, 12'h0F0, 12'hF00};
  typedef enum logic [1:0] {SYNC, RUN, PAUSED} state_t;
endpackage

// File: rtl/bounce_box_gen_if.sv
// bounce_box_gen_if: pixel timing bus from VGA_sync to pixel sources
interface bounce_box_gen_if;
  logic pix_en;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic video_on;
  modport master(output pix_en, pixel_x, pixel_y, video_on);
  modport slave(input pix_en, pixel_x, pixel_y, video_on);
endinterface

// File: rtl/bounce_box_gen_axis.sv
// bounce_axis: one axis of box motion, clamps at 0/MAX and flips direction on a bounce
module bounce_axis #(
  parameter int MAX = 608,
  parameter int STEP = 2,
  parameter int INIT = 304
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [9:0] pos,
  output logic       bounce
);
  localparam logic [10:0] MAX_W = 11'(MAX);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0] MAX10 = 10'(MAX);
  localparam logic [9:0] STEP10 = 10'(STEP);
  logic [9:0] pos_q, pos_d;
  logic dir_q, dir_d;
  logic [10:0] sum;
  // dir_q=1 means moving towards zero
  always_comb begin
    sum = {1'b0, pos_q} + STEP_W;
    bounce = step && (dir_q ? ({1'b0, pos_q} <= STEP_W) : (sum >= MAX_W));
    pos_d = !step ? pos_q : dir_q ? (bounce ? '0 : pos_q - STEP10) : (bounce ? MAX10 : sum[9:0]);
    dir_d = dir_q ^ bounce;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos_q <= 10'(INIT);
      dir_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  assign pos = pos_q;
endmodule

// File: rtl/bounce_box_gen.sv
// bounce_box_gen: border plus a bouncing, colour-cycling square rendered from VGA_sync coordinates
module bounce_box_gen import vga_pkg::*; #(
  parameter int BOX_SIZE = 32,
  parameter int STEP = 2,
  parameter int INIT_X = 304,
  parameter int INIT_Y = 224
) (
  input  logic              clk,
  input  logic              rst_n,
  bounce_box_gen_if.slave   vif,
  input  logic              pause,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [9:0]        box_x,
  output logic [9:0]        box_y,
  output logic              frame_tick
);
  state_t state_q, state_d;
  logic [11:0] rgb_q, rgb_d;
  logic [2:0] col_q, col_d;
  logic taken_q, taken_d;
  logic evt, step, bnc_x, bnc_y, border, in_box;
  logic [10:0] px, py, bx, by;
  bounce_axis #(.MAX(H_ACTIVE - BOX_SIZE), .STEP(STEP), .INIT(INIT_X)) u_x (
    .clk(clk), .rst_n(rst_n), .step(step), .pos(box_x), .bounce(bnc_x)
  );
  bounce_axis #(.MAX(V_ACTIVE - BOX_SIZE), .STEP(STEP), .INIT(INIT_Y)) u_y (
    .clk(clk), .rst_n(rst_n), .step(step), .pos(box_y), .bounce(bnc_y)
  );
  // taken_q blocks a second event until the pixel stream leaves the last active line
  always_comb begin
    px = {1'b0, vif.pixel_x};
    py = {1'b0, vif.pixel_y};
    bx = {1'b0, box_x};
    by = {1'b0, box_y};
    evt = vif.pix_en && px == 11'(H_ACTIVE) && py == 11'(V_ACTIVE - 1) && !taken_q;
    frame_tick = evt && state_q != SYNC;
    step = frame_tick && !pause;
    taken_d = vif.pix_en ? (py == 11'(V_ACTIVE - 1) && (taken_q || evt)) : taken_q;
    col_d = col_q + 3'(bnc_x || bnc_y);
    state_d = state_q == SYNC ? ((vif.pix_en && px == '0 && py == '0) ? RUN : SYNC)
            : frame_tick ? (pause ? PAUSED : RUN) : state_q;
    border = px == '0 || px == 11'(H_ACTIVE - 1) || py == '0 || py == 11'(V_ACTIVE - 1);
    in_box = px >= bx && px < bx + 11'(BOX_SIZE) && py >= by && py < by + 11'(BOX_SIZE);
    rgb_d = !vif.pix_en ? rgb_q
          : (state_q == SYNC || !vif.video_on) ? 12'h000
          : border ? 12'hFFF : in_box ? PALETTE[col_q] : 12'h000;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= SYNC;
      rgb_q <= '0;
      col_q <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rgb_q <= rgb_d;
      col_q <= col_d;
      taken_q <= taken_d;
    end
  assign red = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue = rgb_q[3:0];
endmodule

// File: tb/tb_bounce_box_gen.sv
// tb_bounce_box_gen: directed checks of reset, motion, bounces, pause and render
module tb_bounce_box_gen;
  logic clk = 0, rst_n = 0, pause = 0;
  logic [3:0] r, g, b, rc, gc, bc;
  logic [9:0] bx, by, cx, cy;
  logic tk, tkc, tick_s, tick_a, tickc_s;
  int checks = 0, errors = 0;
  bounce_box_gen_if bif();
  bounce_box_gen u (
    .clk(clk), .rst_n(rst_n), .vif(bif), .pause(pause), .red(r), .green(g), .blue(b),
    .box_x(bx), .box_y(by), .frame_tick(tk)
  );
  bounce_box_gen #(.INIT_X(606), .INIT_Y(446)) uc (
    .clk(clk), .rst_n(rst_n), .vif(bif), .pause(1'b0), .red(rc), .green(gc), .blue(bc),
    .box_x(cx), .box_y(cy), .frame_tick(tkc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic v);
    @(negedge clk);
    bif.pixel_x = x;
    bif.pixel_y = y;
    bif.video_on = v;
    bif.pix_en = 1;
    #1 tick_s = tk;
    tickc_s = tkc;
    @(negedge clk);
    bif.pix_en = 0;
    #1 tick_a = tk;
    repeat (2) @(negedge clk);
  endtask
  task automatic frame();
    pix(0, 0, 1);
    pix(640, 479, 0);
    chk("tick", 32'(tick_s), 1);
    chk("tick_width", 32'(tick_a), 0);
  endtask
  initial begin
    bif.pix_en = 0;
    bif.pixel_x = 0;
    bif.pixel_y = 0;
    bif.video_on = 0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {r, g, b}, 12'h000);
    chk("rst_box", {bx, by}, {10'd304, 10'd224});
    chk("rst_tick", 32'(tk), 0);
    rst_n = 1;
    pix(640, 479, 0);
    chk("sync_tick", 32'(tick_s), 0);
    chk("sync_box", {bx, by}, {10'd304, 10'd224});
    pix(0, 100, 1);
    chk("sync_rgb", {r, g, b}, 12'h000);
    pix(0, 0, 1);
    pix(310, 230, 1);
    chk("box_in", {r, g, b}, 12'hF00);
    pix(335, 255, 1);
    chk("box_corner_in", {r, g, b}, 12'hF00);
    pix(0, 100, 1);
    chk("border", {r, g, b}, 12'hFFF);
    pix(336, 230, 1);
    chk("box_right_out", {r, g, b}, 12'h000);
    pix(310, 256, 1);
    chk("box_below_out", {r, g, b}, 12'h000);
    pix(310, 230, 0);
    chk("video_off", {r, g, b}, 12'h000);
    pix(640, 479, 0);
    chk("ev1_tick", 32'(tick_s), 1);
    chk("ev1_width", 32'(tick_a), 0);
    chk("ev1_box", {bx, by}, {10'd306, 10'd226});
    chk("corner_tick", 32'(tickc_s), 1);
    chk("corner_box", {cx, cy}, {10'd608, 10'd448});
    pix(640, 479, 0);
    chk("once_tick", 32'(tick_s), 0);
    chk("once_box", {bx, by}, {10'd306, 10'd226});
    pix(310, 230, 1);
    chk("col0", {r, g, b}, 12'hF00);
    pix(610, 450, 1);
    chk("corner_col", {rc, gc, bc}, 12'h0F0);
    chk("corner_other", {r, g, b}, 12'h000);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("pause_box", {bx, by}, {10'd306, 10'd226});
    end
    pause = 0;
    frame();
    chk("release_box", {bx, by}, {10'd308, 10'd228});
    chk("corner_run_box", {cx, cy}, {10'd600, 10'd440});
    pix(601, 441, 1);
    chk("corner_once", {rc, gc, bc}, 12'h0F0);
    repeat (149) frame();
    chk("pre_box", {bx, by}, {10'd606, 10'd370});
    pix(607, 371, 1);
    chk("pre_col", {r, g, b}, 12'h0F0);
    frame();
    chk("bounce_box", {bx, by}, {10'd608, 10'd368});
    pix(610, 370, 1);
    chk("bounce_col", {r, g, b}, 12'h00F);
    frame();
    chk("back_box", {bx, by}, {10'd606, 10'd366});
    pix(0, 100, 1);
    chk("pre_rst_rgb", {r, g, b}, 12'hFFF);
    bif.pixel_x = 100;
    bif.pixel_y = 50;
    #1 rst_n = 0;
    #1 chk("async_rgb", {r, g, b}, 12'h000);
    chk("async_box", {bx, by}, {10'd304, 10'd224});
    @(negedge clk);
    rst_n = 1;
    pix(640, 479, 0);
    chk("rst_sync_tick", 32'(tick_s), 0);
    frame();
    chk("rst_frame_box", {bx, by}, {10'd306, 10'd226});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
